reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal values 2..8.
REQ-002 Parameter WIDTH, default 16: data width of each bank register.
REQ-003 Parameter NREG, default 4: number of bank registers; power of two, 2..16.
REQ-004 Parameter AW, default $clog2(NREG): register address width.
REQ-005 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port req_valid, input, NREQ: bit i means requester i has a write pending.
REQ-008 Port req_addr, input, NREQ*AW: requester i target register, slice [i*AW +: AW].
REQ-009 Port req_data, input, NREQ*WIDTH: requester i write data, slice [i*WIDTH +: WIDTH].
REQ-010 Port req_ready, output, NREQ: bit i high means requester i's write is accepted on this edge.
REQ-011 Port rd_addr, input, AW: read select.
REQ-012 Port rd_data, output, WIDTH: combinational read of bank[rd_addr].
REQ-013 Port grant_valid, output, 1: registered; a write was accepted on the previous edge.
REQ-014 Port grant_id, output, $clog2(NREQ): registered; index of the last accepted requester.
REQ-015 Port conflict_cnt, output, 8: saturating count of contended cycles.

Function
REQ-016 Arbitration is round-robin using a registered pointer ptr in 0..NREQ-1.
- Winner is the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo NREQ.
REQ-017 At most one req_ready bit is high in any cycle.
- req_ready is combinational from req_valid and ptr.
- req_ready is all-zero when req_valid is all-zero.
REQ-018 A transfer occurs on each edge where req_valid[i]=req_ready[i]=1.
- bank[req_addr slice i] <= req_data slice i.
- ptr <= (i+1) mod NREQ.
REQ-019 With no transfer, ptr and the bank hold their values.
REQ-020 Write-to-read latency is one cycle: the new value appears on rd_data in the cycle after the accepting edge when rd_addr matches.
REQ-021 A read of an address in the same cycle as a write to it returns the old value; there is no bypass.
REQ-022 On every edge, grant_valid <= |req_ready and grant_id <= winner index.
- grant_id holds its value when grant_valid goes to 0.
REQ-023 conflict_cnt increments on every edge where two or more req_valid bits are high.
- It saturates at 255 and never wraps.
REQ-024 Requesters hold valid, addr and data stable until ready; a requester that drops valid early simply loses its slot.
REQ-025 With N requesters continuously valid, each is granted exactly once in every N consecutive grants, so no requester starves.

Reset
REQ-026 While rst_n=0, the following outputs and state are forced immediately, independent of clk:
- ptr=0, all bank registers=0, grant_valid=0, grant_id=0, conflict_cnt=0.
REQ-027 During reset, req_ready is forced to 0; no write occurs on any edge while rst_n=0.
REQ-028 Reset asserted mid-stream discards the in-flight grant; after release, arbitration restarts from ptr=0.
REQ-029 Reset deassertion is synchronised externally; the block needs no internal synchroniser.

Structure
REQ-030 Shared package reg_arb_pkg holds:
- default NREQ, WIDTH and NREG constants;
- the conflict counter width (8) and its saturation constant (255).
REQ-031 Sub-module rr_pick is a combinational round-robin priority picker.
- Inputs: valid vector and ptr.
- Outputs: one-hot grant and binary index.
REQ-032 The bank storage is an array of WIDTH-bit registers with per-entry write enable, built inside the top module.

Verification
REQ-033 Reset: drive rst_n=0 mid-clock with bank nonzero.
- rd_data=0 for all rd_addr immediately.
- req_ready=0, conflict_cnt=0.
REQ-034 Single writer: req_valid=0001, addr0=2, data0=0xBEEF.
- req_ready=0001 that cycle.
- Next cycle: rd_addr=2 gives 0xBEEF, grant_valid=1, grant_id=0.
REQ-035 Fairness: req_valid=1111 held 8 cycles from ptr=0.
- Grant order is 0,1,2,3,0,1,2,3.
- conflict_cnt=8.
REQ-036 Pointer skip: ptr=2, req_valid=0011.
- Requester 0 granted, then ptr=1.
- Next grant goes to requester 1.
REQ-037 Saturation: 300 contended cycles leaves conflict_cnt=255.
REQ-038 Same-cycle read/write: rd_addr=1 holding 0x1234 while writing 0x5678 to address 1.
- rd_data=0x1234 that cycle, 0x5678 the next.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared constants for the register write arbiter.
// Defaults and the saturating conflict counter limits.
package reg_arb_pkg;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREG  = 4;
  localparam int CNT_W     = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker.
// Searches from ptr upward, modulo N, for the first valid bit.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic w_found;
  int   w_j;

  // First valid requester at or after the pointer wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!w_found && i_valid[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for multi-requester writes into a register bank.
// Combinational read port, registered grant status and conflict count.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*AW-1:0]      req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic [AW-1:0]           rd_addr,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [CNT_W-1:0]        conflict_cnt
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_bank [NREG];
  logic             r_gv;
  logic [PW-1:0]    r_gid;
  logic [CNT_W-1:0] r_cnt;

  logic [NREQ-1:0]  w_gnt;
  logic [PW-1:0]    w_idx;
  logic             w_xfer;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_multi;
  logic [PW-1:0]    w_ptr_nxt;

  rr_pick #(
    .N  (NREQ),
    .IW (PW)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx)
  );

  assign req_ready = rst_n ? w_gnt : '0;
  assign w_xfer    = |req_ready;
  assign w_waddr   = req_addr[w_idx*AW +: AW];
  assign w_wdata   = req_data[w_idx*WIDTH +: WIDTH];
  assign w_multi   = (req_valid & (req_valid - 1'b1)) != '0;
  assign w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  assign rd_data      = r_bank[rd_addr];
  assign grant_valid  = r_gv;
  assign grant_id     = r_gid;
  assign conflict_cnt = r_cnt;

  // Pointer advances past the winner on each transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Bank entries, each with its own write enable
  for (genvar g = 0; g < NREG; g++) begin : g_bank
    logic w_we;
    assign w_we = w_xfer && (w_waddr == AW'(g));
    // Capture the winner's data when this entry is addressed
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_bank[g] <= '0;
      end else if (w_we) begin
        r_bank[g] <= w_wdata;
      end
    end
  end

  // Grant status; id holds while no grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gv  <= 1'b0;
      r_gid <= '0;
    end else begin
      r_gv <= w_xfer;
      if (w_xfer) begin
        r_gid <= w_idx;
      end
    end
  end

  // Saturating count of contended cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_multi && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter.
// NREQ=4, WIDTH=16, NREG=4.
module tb_reg_write_arbiter;
  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_addr;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [7:0]  conflict_cnt;

  int checks = 0;
  int errors = 0;

  reg_write_arbiter #(
    .NREQ  (4),
    .WIDTH (16),
    .NREG  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] a,
                         input logic [15:0] d);
    req_addr[i*2 +: 2]  = a;
    req_data[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    set_req(0, 2'd0, 16'h1111);
    req_valid = 4'b0001;
    tick();
    set_req(0, 2'd3, 16'h3333);
    tick();
    req_valid = 4'b1111;
    set_req(0, 2'd1, 16'h2222);
    set_req(1, 2'd2, 16'h4444);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      checks++;
      if (rd_data !== 16'h0) begin
        errors++;
        $display("FAIL reset_rd addr=%0d got=%h exp=0000", a, rd_data);
      end
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if (conflict_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt);
    end
    checks++;
    if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_grant got=%b/%0d exp=0/0", grant_valid, grant_id);
    end
    tick();
    checks++;
    if (rd_data !== 16'h0) begin
      errors++;
      $display("FAIL reset_nowrite got=%h exp=0000", rd_data);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single_writer();
    do_reset();
    set_req(0, 2'd2, 16'hBEEF);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = '0;
    rd_addr = 2'd2;
    #1;
    checks++;
    if (rd_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL single_rd got=%h exp=beef", rd_data);
    end
    checks++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL single_grant got=%b/%0d exp=1/0", grant_valid, grant_id);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL idle_ready got=%b exp=0000", req_ready);
    end
    tick();
    checks++;
    if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL grant_hold got=%b/%0d exp=0/0", grant_valid, grant_id);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 16'h00A0 + 16'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        errors++;
        $display("FAIL fair_ready k=%0d got=%b exp=%b", k, req_ready,
                 4'(1 << (k % 4)));
      end
      tick();
      checks++;
      if (grant_id !== 2'(k % 4)) begin
        errors++;
        $display("FAIL fair_id k=%0d got=%0d exp=%0d", k, grant_id, k % 4);
      end
    end
    req_valid = '0;
    #1;
    checks++;
    if (conflict_cnt !== 8'd8) begin
      errors++;
      $display("FAIL fair_cnt got=%0d exp=8", conflict_cnt);
    end
    rd_addr = 2'd3;
    #1;
    checks++;
    if (rd_data !== 16'h00A3) begin
      errors++;
      $display("FAIL fair_rd got=%h exp=00a3", rd_data);
    end
  endtask

  task automatic test_pointer_skip();
    do_reset();
    set_req(0, 2'd0, 16'h0C00);
    set_req(1, 2'd1, 16'h0C11);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL skip_ready0 got=%b exp=0001", req_ready);
    end
    tick();
    checks++;
    if (grant_id !== 2'd0) begin
      errors++;
      $display("FAIL skip_id0 got=%0d exp=0", grant_id);
    end
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL skip_ready1 got=%b exp=0010", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (grant_id !== 2'd1 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL skip_id1 got=%b/%0d exp=1/1", grant_valid, grant_id);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    req_valid = 4'b0101;
    for (int k = 0; k < 254; k++) tick();
    checks++;
    if (conflict_cnt !== 8'd254) begin
      errors++;
      $display("FAIL sat_254 got=%0d exp=254", conflict_cnt);
    end
    for (int k = 0; k < 46; k++) tick();
    req_valid = '0;
    checks++;
    if (conflict_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_255 got=%0d exp=255", conflict_cnt);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_req(2, 2'd1, 16'h1234);
    req_valid = 4'b0100;
    tick();
    set_req(3, 2'd1, 16'h5678);
    req_valid = 4'b1000;
    rd_addr = 2'd1;
    #1;
    checks++;
    if (rd_data !== 16'h1234) begin
      errors++;
      $display("FAIL rw_old got=%h exp=1234", rd_data);
    end
    tick();
    req_valid = '0;
    #1;
    checks++;
    if (rd_data !== 16'h5678) begin
      errors++;
      $display("FAIL rw_new got=%h exp=5678", rd_data);
    end
    checks++;
    if (grant_id !== 2'd3) begin
      errors++;
      $display("FAIL rw_id got=%0d exp=3", grant_id);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rd_addr   = '0;
    #12;
    rst_n = 1'b1;
    #1;
    test_reset();
    test_single_writer();
    test_fairness();
    test_pointer_skip();
    test_saturation();
    test_same_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
